// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-supply side of the 4-bit processor core. It holds a 16-entry
// program memory, owns the program counter and presents the current
// instruction as opcode/operand to the control unit. A valid/ready byte
// loader fills the memory before execution starts. HALT is detected locally,
// and JMP can optionally be detected locally as well.
//
// Build option:
//   FETCH_JUMP_EN - when defined, opcode 4'h8 (JMP) loads pc from the operand
//                   on a sampled pc_enable. When undefined, 4'h8 is an
//                   ordinary opcode and pc increments.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   load_mode    in   level-sensitive request to (re)load the program
//   ld_valid     in   loader byte valid
//   ld_data      in   loader instruction byte
//   ld_ready     out  loader may accept a byte (LOAD state and memory not full)
//   ld_done      out  16 bytes written since entering LOAD
//   pc_enable    in   "instruction consumed, advance" from the control unit
//   opcode       out  IR[7:4] in RUN, NOP (4'hE) otherwise
//   operand      out  IR[3:0] in RUN, 0 otherwise
//   pc           out  current program counter
//   instr_valid  out  IR holds mem[pc]
//   halted       out  HALT instruction retired
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_mode,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic               ld_done,
  input  logic               pc_enable,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid,
  output logic               halted
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [INSTR_W-1:0] IR_RESET = INSTR_W'(8'hE0);

`ifdef FETCH_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic                ld_done_q, ld_done_d;

  logic [INSTR_W-1:0]  mem [DEPTH];

  logic                ld_we;
  logic [3:0]          ir_opcode;
  logic [3:0]          ir_operand;

  assign ir_opcode  = ir_q[INSTR_W-1:INSTR_W-4];
  assign ir_operand = ir_q[3:0];

  // ld_done doubles as the "memory full" flag, so the loader stops accepting
  // bytes the cycle after the 16th handshake.
  assign ld_ready = (state_q == ST_LOAD) && !ld_done_q;
  assign ld_we    = ld_ready && ld_valid;

  // Next-state logic for the fetch/load sequencer. Every register holds by
  // default; each state only overrides what it changes.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wptr_d        = wptr_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    ld_done_d     = ld_done_q;

    case (state_q)
      ST_IDLE: begin
        if (load_mode) begin
          state_d   = ST_LOAD;
          wptr_d    = '0;
          ld_done_d = 1'b0;
        end else begin
          state_d       = ST_RUN;
          pc_d          = '0;
          instr_valid_d = 1'b0;
        end
      end

      ST_LOAD: begin
        // A handshake in the same cycle load_mode drops is still taken.
        if (ld_we) begin
          wptr_d = wptr_q + ADDR_W'(1);
          if (wptr_q == ADDR_W'(DEPTH - 1)) begin
            ld_done_d = 1'b1;
          end
        end
        if (!load_mode) begin
          state_d       = ST_RUN;
          pc_d          = '0;
          instr_valid_d = 1'b0;
        end
      end

      ST_RUN: begin
        // A reload request wins over an advance in the same cycle; pc is
        // left alone and restarts at 0 when the loader hands back to RUN.
        if (load_mode) begin
          state_d       = ST_LOAD;
          wptr_d        = '0;
          ld_done_d     = 1'b0;
          instr_valid_d = 1'b0;
        end else begin
          ir_d = mem[pc_q];
          // pc_enable is only meaningful once IR matches mem[pc]; while the
          // refetch is in flight it is ignored.
          if (instr_valid_q && pc_enable) begin
            if (ir_opcode == OP_HALT) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else if (JUMP_EN && (ir_opcode == OP_JMP)) begin
              pc_d          = ADDR_W'(ir_operand);
              instr_valid_d = 1'b0;
            end else begin
              pc_d          = pc_q + ADDR_W'(1);
              instr_valid_d = 1'b0;
            end
          end else begin
            instr_valid_d = 1'b1;
          end
        end
      end

      ST_HALT: begin
        if (load_mode) begin
          state_d       = ST_LOAD;
          wptr_d        = '0;
          ld_done_d     = 1'b0;
          halted_d      = 1'b0;
          instr_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers. Reset is asynchronous and returns everything except
  // the program memory to its power-on values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      wptr_q        <= '0;
      ir_q          <= IR_RESET;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wptr_q        <= wptr_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      ld_done_q     <= ld_done_d;
    end
  end

  // Program memory has no reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[wptr_q] <= ld_data;
    end
  end

  // Only RUN exposes the fetched instruction; every other state shows NOP.
  assign opcode      = (state_q == ST_RUN) ? ir_opcode  : OP_NOP;
  assign operand     = (state_q == ST_RUN) ? ir_operand : 4'h0;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign ld_done     = ld_done_q;

endmodule
